tmon_cmd_sequencer: RTL

Host-side command initiator for `tmon_master`. It queues (operation, data) commands from a controller or bench and drives them one at a time onto the master's `request`/`reqData` inputs. It then waits for the master's `Done`, enforces a completion timeout and reports completion and error status. It is the driving end of the master's command interface, the counterpart of the master consuming those commands.

---
 rtl/tmon_cmd_sequencer_pkg.sv | 32 +++
 rtl/tmon_cmd_sequencer_if.sv | 25 ++
 rtl/tmon_cmd_fifo.sv | 68 ++++++
 rtl/tmon_cmd_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/tmon_cmd_sequencer_pkg.sv
// Shared definitions for the tmon command sequencer: the master's operation
// codes, the sequencer FSM states, the queued command record and a
// saturating counter helper.
package tmon_cmd_sequencer_pkg;

    // Operations understood by tmon_master; NOP is the idle request.
    typedef enum logic [2:0] {
        NOP      = 3'd0,
        SET_FRQ  = 3'd1,
        GET_TEMP = 3'd2,
        SET_THR  = 3'd3,
        RD_STAT  = 3'd4
    } TMON_OP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } TMON_SEQ_STATE;

    // One queued command as stored in the FIFO.
    typedef struct packed {
        TMON_OP     op;
        logic [7:0] data;
    } tmon_cmd_t;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tmon_cmd_sequencer_if.sv
// Push channel into the command sequencer. The controller (or bench) is the
// master and offers commands; the sequencer is the slave and returns ready.
interface tmon_cmd_sequencer_if;
    import tmon_cmd_sequencer_pkg::*;

    logic       push_valid;
    TMON_OP     push_op;
    logic [7:0] push_data;
    logic       push_ready;

    modport master (
        output push_valid,
        output push_op,
        output push_data,
        input  push_ready
    );

    modport slave (
        input  push_valid,
        input  push_op,
        input  push_data,
        output push_ready
    );

endinterface

// File: rtl/tmon_cmd_fifo.sv
// Small synchronous command FIFO for the sequencer. Pointers wrap naturally
// (DEPTH is a power of two); a separate occupancy counter one bit wider
// distinguishes full from empty. The head is read straight from the array so
// an entry written on one edge can be popped on the very next edge.
module tmon_cmd_fifo
    import tmon_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       push,
    input  TMON_OP     push_op,
    input  logic [7:0] push_data,
    input  logic       pop,
    output TMON_OP     head_op,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    tmon_cmd_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    // A push while full is dropped, so nothing is ever overwritten.
    assign do_push = push && !full && !Reset;
    assign do_pop  = pop && !empty;

    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign head_op   = mem[rd_ptr_reg].op;
    assign head_data = mem[rd_ptr_reg].data;

    // Storage array: no reset needed, validity is tracked by the counter.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= '{op: push_op, data: push_data};
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/tmon_cmd_sequencer.sv
// Host-side command initiator for tmon_master. Commands are queued in a
// small FIFO and issued one at a time on request/reqData; the FSM then waits
// for Done (or a timeout), returns to NOP and insists on Done dropping before
// the next issue.
// Optional feature macro: TMON_SEQ_RETRY_EN -- reissue a timed-out command
// once from a held copy before reporting it as failed.
module tmon_cmd_sequencer
    import tmon_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    tmon_cmd_sequencer_if.slave   push_if,
    output TMON_OP                request,
    output logic [7:0]            reqData,
    input  logic                  Done,
    output logic                  busy,
    output logic                  cmd_done,
    output logic                  err_timeout,
    output logic [7:0]            err_count
);

    localparam int             TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    TMON_OP        head_op;
    logic [7:0]    head_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          fifo_push;

    TMON_SEQ_STATE state_reg,       state_next;
    logic [TW-1:0] timer_reg,       timer_next;
    TMON_OP        request_reg,     request_next;
    logic [7:0]    req_data_reg,    req_data_next;
    logic          cmd_done_reg,    cmd_done_next;
    logic          err_timeout_reg, err_timeout_next;
    logic [7:0]    err_count_reg,   err_count_next;
`ifdef TMON_SEQ_RETRY_EN
    logic          retry_reg,       retry_next;
    TMON_OP        held_op_reg,     held_op_next;
    logic [7:0]    held_data_reg,   held_data_next;
`endif

    assign push_if.push_ready = !fifo_full && !Reset;
    assign fifo_push          = push_if.push_valid && push_if.push_ready;

    tmon_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .push      (fifo_push),
        .push_op   (push_if.push_op),
        .push_data (push_if.push_data),
        .pop       (fifo_pop),
        .head_op   (head_op),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state and output decode for the issue/wait/gap sequence.
    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        request_next     = request_reg;
        req_data_next    = req_data_reg;
        cmd_done_next    = 1'b0;
        err_timeout_next = 1'b0;
        err_count_next   = err_count_reg;
        fifo_pop         = 1'b0;
`ifdef TMON_SEQ_RETRY_EN
        retry_next       = retry_reg;
        held_op_next     = held_op_reg;
        held_data_next   = held_data_reg;
`endif
        case (state_reg)
            IDLE: begin
`ifdef TMON_SEQ_RETRY_EN
                // A pending retry takes priority over the queue.
                if (retry_reg) begin
                    request_next  = held_op_reg;
                    req_data_next = held_data_reg;
                    timer_next    = '0;
                    state_next    = WAIT;
                end else
`endif
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    request_next  = head_op;
                    req_data_next = head_data;
                    timer_next    = '0;
                    state_next    = WAIT;
`ifdef TMON_SEQ_RETRY_EN
                    held_op_next   = head_op;
                    held_data_next = head_data;
`endif
                end
            end
            WAIT: begin
                timer_next = timer_reg + TW'(1);
                // Done is checked first so it wins over a coincident timeout.
                if (Done) begin
                    request_next  = NOP;
                    req_data_next = 8'h00;
                    cmd_done_next = 1'b1;
                    state_next    = GAP;
`ifdef TMON_SEQ_RETRY_EN
                    retry_next    = 1'b0;
`endif
                end else if (timer_reg == TIMER_LAST) begin
                    request_next  = NOP;
                    req_data_next = 8'h00;
                    state_next    = GAP;
`ifdef TMON_SEQ_RETRY_EN
                    if (!retry_reg) begin
                        retry_next = 1'b1;
                    end else begin
                        retry_next       = 1'b0;
                        err_timeout_next = 1'b1;
                        err_count_next   = sat_inc8(err_count_reg);
                    end
`else
                    err_timeout_next = 1'b1;
                    err_count_next   = sat_inc8(err_count_reg);
`endif
                end
            end
            GAP: begin
                // Hold NOP until the master has released Done.
                if (!Done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight command silently.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg       <= IDLE;
            timer_reg       <= '0;
            request_reg     <= NOP;
            req_data_reg    <= 8'h00;
            cmd_done_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_count_reg   <= 8'h00;
`ifdef TMON_SEQ_RETRY_EN
            retry_reg       <= 1'b0;
            held_op_reg     <= NOP;
            held_data_reg   <= 8'h00;
`endif
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            request_reg     <= request_next;
            req_data_reg    <= req_data_next;
            cmd_done_reg    <= cmd_done_next;
            err_timeout_reg <= err_timeout_next;
            err_count_reg   <= err_count_next;
`ifdef TMON_SEQ_RETRY_EN
            retry_reg       <= retry_next;
            held_op_reg     <= held_op_next;
            held_data_reg   <= held_data_next;
`endif
        end
    end

    assign request     = request_reg;
    assign reqData     = req_data_reg;
    assign cmd_done    = cmd_done_reg;
    assign err_timeout = err_timeout_reg;
    assign err_count   = err_count_reg;
`ifdef TMON_SEQ_RETRY_EN
    assign busy = (state_reg != IDLE) || !fifo_empty || retry_reg;
`else
    assign busy = (state_reg != IDLE) || !fifo_empty;
`endif

endmodule
